regfile_wb_arbiter: RTL and testbench

Write-port arbiter and scoreboard for the RV32IM register file. It shares the single register-file write port between the in-order pipeline writeback and the multi-cycle MUL/DIV unit. MUL/DIV results are buffered in a small FIFO, and a per-register pending scoreboard drives operand-hazard flags to the issue logic. The block sits between the writeback stage, the M-extension unit, and the `register_file` write port (`i_we`/`i_rd_addr`/`i_rd`).

---
 rtl/regfile_wb_arbiter.sv | 178 +++++++++++++++++
 tb/tb_regfile_wb_arbiter.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_wb_arbiter.sv
// Shares the register-file write port between pipeline writeback and MUL/DIV results.
// MUL/DIV results queue in a small FIFO; a per-register scoreboard flags operand hazards.
// Ports: i_clk/i_rst (async, active-low); i_pipe_* pipeline writeback in; o_pipe_stall;
//   i_md_issue/_addr scoreboard set; i_md_valid/_rd_addr/_rd + o_md_ready result handshake;
//   i_rsN_addr -> o_rsN_busy hazard flags; o_we/o_rd_addr/o_rd registered write port;
//   o_md_pending any MUL/DIV write outstanding.
// Option: define REGFILE_WB_STARVE_GUARD_EN to force a FIFO drain after STARVE_LIMIT losses.
module regfile_wb_arbiter #(
  parameter int NUM_REGISTER = 32,
  parameter int DATA_WIDTH   = 32,
  parameter int FIFO_DEPTH   = 2,
  parameter int STARVE_LIMIT = 4,
  localparam int AW = $clog2(NUM_REGISTER)
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_pipe_we,
  input  logic [AW-1:0]         i_pipe_rd_addr,
  input  logic [DATA_WIDTH-1:0] i_pipe_rd,
  output logic                  o_pipe_stall,
  input  logic                  i_md_issue,
  input  logic [AW-1:0]         i_md_issue_addr,
  input  logic                  i_md_valid,
  input  logic [AW-1:0]         i_md_rd_addr,
  input  logic [DATA_WIDTH-1:0] i_md_rd,
  output logic                  o_md_ready,
  input  logic [AW-1:0]         i_rs1_addr,
  input  logic [AW-1:0]         i_rs2_addr,
  output logic                  o_rs1_busy,
  output logic                  o_rs2_busy,
  output logic                  o_we,
  output logic [AW-1:0]         o_rd_addr,
  output logic [DATA_WIDTH-1:0] o_rd,
  output logic                  o_md_pending
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  if (FIFO_DEPTH < 2 || STARVE_LIMIT < 1) begin : g_bad_param
    $error("regfile_wb_arbiter: bad FIFO_DEPTH/STARVE_LIMIT");
  end

  logic [AW-1:0]         r_q_addr [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] r_q_data [FIFO_DEPTH];
  logic [PW-1:0]         r_wptr;
  logic [PW-1:0]         r_rptr;
  logic [CW-1:0]         r_count;

  logic                  r_we;
  logic                  r_md_src;
  logic [AW-1:0]         r_rd_addr;
  logic [DATA_WIDTH-1:0] r_rd;
  logic [NUM_REGISTER-1:0] r_sb;
  logic [NUM_REGISTER-1:0] w_sb_next;

  logic w_empty;
  logic w_full;
  logic w_push;
  logic w_pop;
  logic w_stall;
  logic w_pipe_grant;
  logic w_head_grant;

  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == CW'(FIFO_DEPTH));

  // x0 results complete the handshake but never occupy a slot
  assign w_push = i_md_valid && !w_full && (i_md_rd_addr != '0);

  // During a stall pulse the pipeline is ignored, so the head wins
  assign w_pipe_grant = !w_stall && i_pipe_we && (i_pipe_rd_addr != '0);
  assign w_head_grant = !w_empty && !w_pipe_grant;
  assign w_pop        = w_head_grant;

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        r_q_addr[i] <= '0;
        r_q_data[i] <= '0;
      end
    end else begin
      if (w_push) begin
        r_q_addr[r_wptr] <= i_md_rd_addr;
        r_q_data[r_wptr] <= i_md_rd;
        r_wptr <= r_wptr + PW'(1);
      end
      if (w_pop) begin
        r_rptr <= r_rptr + PW'(1);
      end
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_we      <= 1'b0;
      r_md_src  <= 1'b0;
      r_rd_addr <= '0;
      r_rd      <= '0;
    end else begin
      r_we     <= w_pipe_grant || w_head_grant;
      r_md_src <= w_head_grant;
      if (w_head_grant) begin
        r_rd_addr <= r_q_addr[r_rptr];
        r_rd      <= r_q_data[r_rptr];
      end else if (w_pipe_grant) begin
        r_rd_addr <= i_pipe_rd_addr;
        r_rd      <= i_pipe_rd;
      end
    end
  end

  // Clear lands on the same edge the register file commits;
  // a simultaneous issue to that address keeps the bit set.
  always_comb begin
    w_sb_next = r_sb;
    if (r_we && r_md_src) begin
      w_sb_next[r_rd_addr] = 1'b0;
    end
    if (i_md_issue && (i_md_issue_addr != '0)) begin
      w_sb_next[i_md_issue_addr] = 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_sb <= '0;
    end else begin
      r_sb <= w_sb_next;
    end
  end

`ifdef REGFILE_WB_STARVE_GUARD_EN
  localparam int SW = $clog2(STARVE_LIMIT + 1);

  logic [SW-1:0] r_starve;
  logic          r_stall;
  logic          w_lose;

  assign w_lose  = !w_empty && w_pipe_grant;
  assign w_stall = r_stall;

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_starve <= '0;
      r_stall  <= 1'b0;
    end else begin
      if (w_head_grant || w_empty) begin
        r_starve <= '0;
      end else if (w_lose) begin
        r_starve <= r_starve + SW'(1);
      end
      // One-cycle pulse on the loss that reaches the limit
      r_stall <= w_lose && ((r_starve + SW'(1)) == SW'(STARVE_LIMIT));
    end
  end
`else
  assign w_stall = 1'b0;
`endif

  assign o_pipe_stall = w_stall;
  assign o_md_ready   = !w_full;
  assign o_rs1_busy   = (i_rs1_addr != '0) && r_sb[i_rs1_addr];
  assign o_rs2_busy   = (i_rs2_addr != '0) && r_sb[i_rs2_addr];
  assign o_we         = r_we;
  assign o_rd_addr    = r_rd_addr;
  assign o_rd         = r_rd;
  assign o_md_pending = (|r_sb) || !w_empty;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed self-checking bench for regfile_wb_arbiter.
// Covers reset, pipeline and MUL/DIV writes, scoreboard, conflicts, FIFO full, x0.
module tb_regfile_wb_arbiter;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic        i_pipe_we;
  logic [4:0]  i_pipe_rd_addr;
  logic [31:0] i_pipe_rd;
  logic        o_pipe_stall;
  logic        i_md_issue;
  logic [4:0]  i_md_issue_addr;
  logic        i_md_valid;
  logic [4:0]  i_md_rd_addr;
  logic [31:0] i_md_rd;
  logic        o_md_ready;
  logic [4:0]  i_rs1_addr;
  logic [4:0]  i_rs2_addr;
  logic        o_rs1_busy;
  logic        o_rs2_busy;
  logic        o_we;
  logic [4:0]  o_rd_addr;
  logic [31:0] o_rd;
  logic        o_md_pending;

  int n_tests = 0;
  int n_fail  = 0;

  regfile_wb_arbiter dut (
    .i_clk           (i_clk),
    .i_rst           (i_rst),
    .i_pipe_we       (i_pipe_we),
    .i_pipe_rd_addr  (i_pipe_rd_addr),
    .i_pipe_rd       (i_pipe_rd),
    .o_pipe_stall    (o_pipe_stall),
    .i_md_issue      (i_md_issue),
    .i_md_issue_addr (i_md_issue_addr),
    .i_md_valid      (i_md_valid),
    .i_md_rd_addr    (i_md_rd_addr),
    .i_md_rd         (i_md_rd),
    .o_md_ready      (o_md_ready),
    .i_rs1_addr      (i_rs1_addr),
    .i_rs2_addr      (i_rs2_addr),
    .o_rs1_busy      (o_rs1_busy),
    .o_rs2_busy      (o_rs2_busy),
    .o_we            (o_we),
    .o_rd_addr       (o_rd_addr),
    .o_rd            (o_rd),
    .o_md_pending    (o_md_pending)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic chk_wr(input string tag, input logic we,
                        input logic [4:0] a, input logic [31:0] d);
    chk({tag, "_we"}, 32'(o_we), 32'(we));
    if (we) begin
      chk({tag, "_addr"}, 32'(o_rd_addr), 32'(a));
      chk({tag, "_data"}, o_rd, d);
    end
  endtask

  initial begin
    i_rst = 1'b0;
    i_pipe_we = 1'b0; i_pipe_rd_addr = '0; i_pipe_rd = '0;
    i_md_issue = 1'b0; i_md_issue_addr = '0;
    i_md_valid = 1'b0; i_md_rd_addr = '0; i_md_rd = '0;
    i_rs1_addr = '0; i_rs2_addr = '0;
    step(); step();
    chk("rst_we", 32'(o_we), 0);
    chk("rst_addr", 32'(o_rd_addr), 0);
    chk("rst_rd", o_rd, 0);
    chk("rst_stall", 32'(o_pipe_stall), 0);
    chk("rst_ready", 32'(o_md_ready), 1);
    chk("rst_pend", 32'(o_md_pending), 0);
    i_rst = 1'b1;
    step();

    // Pipeline write x5
    i_pipe_we = 1'b1; i_pipe_rd_addr = 5'd5; i_pipe_rd = 32'hDEADBEEF;
    step();
    chk_wr("pipe5", 1'b1, 5'd5, 32'hDEADBEEF);
    i_pipe_we = 1'b0;
    step();
    chk("pipe5_pulse", 32'(o_we), 0);

    // Scoreboard round trip on x7
    i_rs1_addr = 5'd7;
    i_md_issue = 1'b1; i_md_issue_addr = 5'd7;
    #1;
    chk("sb7_pre", 32'(o_rs1_busy), 0);
    step();
    i_md_issue = 1'b0;
    chk("sb7_busy", 32'(o_rs1_busy), 1);
    chk("sb7_pend", 32'(o_md_pending), 1);
    step();
    chk("sb7_hold", 32'(o_rs1_busy), 1);
    i_md_valid = 1'b1; i_md_rd_addr = 5'd7; i_md_rd = 32'h12345678;
    step();
    i_md_valid = 1'b0;
    chk("sb7_acc_we", 32'(o_we), 0);
    chk("sb7_acc_busy", 32'(o_rs1_busy), 1);
    step();
    chk_wr("sb7_wr", 1'b1, 5'd7, 32'h12345678);
    chk("sb7_wr_busy", 32'(o_rs1_busy), 1);
    step();
    chk("sb7_clr", 32'(o_rs1_busy), 0);
    chk("sb7_idle", 32'(o_we), 0);
    chk("sb7_pend0", 32'(o_md_pending), 0);

    // Conflict: pipeline x1 vs MUL/DIV x2
    i_rs2_addr = 5'd2;
    i_md_issue = 1'b1; i_md_issue_addr = 5'd2;
    step();
    i_md_issue = 1'b0;
    chk("cf_busy2", 32'(o_rs2_busy), 1);
    i_pipe_we = 1'b1; i_pipe_rd_addr = 5'd1; i_pipe_rd = 32'h1;
    i_md_valid = 1'b1; i_md_rd_addr = 5'd2; i_md_rd = 32'h2;
    step();
    i_pipe_we = 1'b0; i_md_valid = 1'b0;
    chk_wr("cf_x1", 1'b1, 5'd1, 32'h1);
    step();
    chk_wr("cf_x2", 1'b1, 5'd2, 32'h2);
    step();
    chk("cf_idle", 32'(o_we), 0);
    chk("cf_clr2", 32'(o_rs2_busy), 0);

    // FIFO full under continuous pipeline traffic
    i_md_issue = 1'b1;
    i_md_issue_addr = 5'd8;  step();
    i_md_issue_addr = 5'd9;  step();
    i_md_issue_addr = 5'd10; step();
    i_md_issue = 1'b0;
    i_pipe_we = 1'b1; i_pipe_rd_addr = 5'd3; i_pipe_rd = 32'h3000_0001;
    i_md_valid = 1'b1; i_md_rd_addr = 5'd8; i_md_rd = 32'hA8;
    step();
    chk_wr("ff_a1", 1'b1, 5'd3, 32'h3000_0001);
    chk("ff_rdy1", 32'(o_md_ready), 1);
    i_pipe_rd = 32'h3000_0002;
    i_md_rd_addr = 5'd9; i_md_rd = 32'hA9;
    step();
    chk_wr("ff_a2", 1'b1, 5'd3, 32'h3000_0002);
    chk("ff_rdy2", 32'(o_md_ready), 0);
    i_pipe_rd = 32'h3000_0003;
    i_md_rd_addr = 5'd10; i_md_rd = 32'hAA;
    step();
    chk_wr("ff_a3", 1'b1, 5'd3, 32'h3000_0003);
    chk("ff_rdy3", 32'(o_md_ready), 0);
`ifdef REGFILE_WB_STARVE_GUARD_EN
    i_pipe_rd = 32'h3000_0004;
    step();
    chk_wr("ff_a4", 1'b1, 5'd3, 32'h3000_0004);
    chk("ff_a4_stall", 32'(o_pipe_stall), 0);
    i_pipe_rd = 32'h3000_0005;
    step();
    chk_wr("ff_a5", 1'b1, 5'd3, 32'h3000_0005);
    chk("ff_a5_stall", 32'(o_pipe_stall), 1);
    step();
    chk_wr("ff_drain8", 1'b1, 5'd8, 32'hA8);
    chk("ff_a6_stall", 32'(o_pipe_stall), 0);
    chk("ff_a6_rdy", 32'(o_md_ready), 1);
    step();
    chk_wr("ff_a7", 1'b1, 5'd3, 32'h3000_0005);
    chk("ff_a7_rdy", 32'(o_md_ready), 0);
    i_pipe_we = 1'b0; i_md_valid = 1'b0;
    step();
    chk_wr("ff_x9", 1'b1, 5'd9, 32'hA9);
    step();
    chk_wr("ff_x10", 1'b1, 5'd10, 32'hAA);
    step();
`else
    for (int k = 4; k < 8; k++) begin
      i_pipe_rd = 32'h3000_0000 + 32'(k);
      step();
      chk_wr("ff_hold", 1'b1, 5'd3, 32'h3000_0000 + 32'(k));
      chk("ff_hold_rdy", 32'(o_md_ready), 0);
      chk("ff_hold_stall", 32'(o_pipe_stall), 0);
    end
    i_pipe_we = 1'b0;
    step();
    chk_wr("ff_x8", 1'b1, 5'd8, 32'hA8);
    chk("ff_x8_rdy", 32'(o_md_ready), 1);
    step();
    i_md_valid = 1'b0;
    chk_wr("ff_x9", 1'b1, 5'd9, 32'hA9);
    step();
    chk_wr("ff_x10", 1'b1, 5'd10, 32'hAA);
    step();
`endif
    chk("ff_idle", 32'(o_we), 0);
    chk("ff_pend0", 32'(o_md_pending), 0);

    // x0 handling
    i_rs1_addr = 5'd0;
    i_pipe_we = 1'b1; i_pipe_rd_addr = 5'd0; i_pipe_rd = 32'hFFFFFFFF;
    i_md_valid = 1'b1; i_md_rd_addr = 5'd0; i_md_rd = 32'h5;
    i_md_issue = 1'b1; i_md_issue_addr = 5'd0;
    #1;
    chk("x0_rdy", 32'(o_md_ready), 1);
    step();
    i_pipe_we = 1'b0; i_md_valid = 1'b0; i_md_issue = 1'b0;
    chk("x0_we", 32'(o_we), 0);
    chk("x0_rdy2", 32'(o_md_ready), 1);
    chk("x0_busy", 32'(o_rs1_busy), 0);
    chk("x0_pend", 32'(o_md_pending), 0);
    step();
    chk("x0_we2", 32'(o_we), 0);

    // Reset with two results buffered
    i_md_issue = 1'b1;
    i_md_issue_addr = 5'd11; step();
    i_md_issue_addr = 5'd12; step();
    i_md_issue = 1'b0;
    i_rs1_addr = 5'd11;
    i_pipe_we = 1'b1; i_pipe_rd_addr = 5'd4; i_pipe_rd = 32'h44;
    i_md_valid = 1'b1; i_md_rd_addr = 5'd11; i_md_rd = 32'hB1;
    step();
    i_md_rd_addr = 5'd12; i_md_rd = 32'hB2;
    step();
    chk("mr_full", 32'(o_md_ready), 0);
    chk("mr_pend", 32'(o_md_pending), 1);
    chk("mr_busy", 32'(o_rs1_busy), 1);
    i_rst = 1'b0;
    i_pipe_we = 1'b0; i_md_valid = 1'b0;
    #2;
    chk("mr_we", 32'(o_we), 0);
    chk("mr_addr", 32'(o_rd_addr), 0);
    chk("mr_rd", o_rd, 0);
    chk("mr_stall", 32'(o_pipe_stall), 0);
    chk("mr_rdy", 32'(o_md_ready), 1);
    chk("mr_pend0", 32'(o_md_pending), 0);
    chk("mr_busy0", 32'(o_rs1_busy), 0);
    #2;
    i_rst = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step();
      chk("mr_no_we", 32'(o_we), 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
